// File: rtl/draw_box.sv
// draw_box_top: bounding box of motion between a frame and its base, drawn onto a held copy of the frame.
module draw_box_fifo #(
  parameter int DW = 24,
  parameter int DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [DW-1:0]                  din,
  input  logic                           rd_en,
  output logic [DW-1:0]                  dout,
  output logic [$clog2(DEPTH+1)-1:0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic we, re;
  assign we = wr_en && level != LW'(DEPTH);
  assign re = rd_en && level != '0;
  assign dout = level == '0 ? '0 : mem[rptr];
  always_ff @(posedge clock)
    if (we) mem[wptr] <= din;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (we) wptr <= wptr == AW'(DEPTH-1) ? '0 : wptr + 1'b1;
      if (re) rptr <= rptr == AW'(DEPTH-1) ? '0 : rptr + 1'b1;
      level <= level + LW'(we) - LW'(re);
    end
endmodule

module draw_box_top #(
  parameter int          WIDTH = 768,
  parameter int          HEIGHT = 576,
  parameter int          THRESHOLD = 60,
  parameter logic [23:0] BOX_COLOR = 24'h0000FF,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_wr_en,
  input  logic [23:0] in_din,
  output logic        in_full,
  input  logic        base_wr_en,
  input  logic [23:0] base_din,
  output logic        base_full,
  input  logic        hold_wr_en,
  input  logic [23:0] hold_din,
  output logic        hold_full,
  input  logic        out_rd_en,
  output logic        out_empty,
  output logic [23:0] out_dout
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  typedef enum logic {SCAN, DRAW} state_t;
  state_t state;
  logic [XW-1:0] x, xmin, xmax;
  logic [YW-1:0] y, ymin, ymax;
  logic found, pend, pop, hold_acc, motion, on_box, x_last, y_last;
  logic [23:0] pend_data, in_dout, base_dout;
  logic [9:0] sum_in, sum_base;
  logic [LW-1:0] in_lvl, base_lvl, out_lvl;
  draw_box_fifo #(.DW(24), .DEPTH(FIFO_DEPTH)) u_in (
    .clock(clock), .reset(reset), .wr_en(in_wr_en), .din(in_din),
    .rd_en(pop), .dout(in_dout), .level(in_lvl));
  draw_box_fifo #(.DW(24), .DEPTH(FIFO_DEPTH)) u_base (
    .clock(clock), .reset(reset), .wr_en(base_wr_en), .din(base_din),
    .rd_en(pop), .dout(base_dout), .level(base_lvl));
  draw_box_fifo #(.DW(24), .DEPTH(FIFO_DEPTH)) u_out (
    .clock(clock), .reset(reset), .wr_en(pend), .din(pend_data),
    .rd_en(out_rd_en), .dout(out_dout), .level(out_lvl));
  assign in_full = in_lvl == LW'(FIFO_DEPTH);
  assign base_full = base_lvl == LW'(FIFO_DEPTH);
  assign out_empty = out_lvl == '0;
  // The accepted hold pixel lands in the out FIFO a cycle later, so reserve a slot for it.
  assign hold_full = state == SCAN || out_lvl == LW'(FIFO_DEPTH) ||
                     (pend && out_lvl == LW'(FIFO_DEPTH-1));
  assign hold_acc = hold_wr_en && !hold_full;
  assign pop = state == SCAN && in_lvl != '0 && base_lvl != '0;
  assign sum_in = 10'(in_dout[23:16]) + 10'(in_dout[15:8]) + 10'(in_dout[7:0]);
  assign sum_base = 10'(base_dout[23:16]) + 10'(base_dout[15:8]) + 10'(base_dout[7:0]);
  assign motion = (sum_in > sum_base ? sum_in - sum_base : sum_base - sum_in) > 10'(THRESHOLD);
  assign x_last = x == XW'(WIDTH-1);
  assign y_last = y == YW'(HEIGHT-1);
  assign on_box = found && (((x == xmin || x == xmax) && y >= ymin && y <= ymax) ||
                            ((y == ymin || y == ymax) && x >= xmin && x <= xmax));
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= SCAN;
      x <= '0;
      y <= '0;
      xmin <= XW'(WIDTH-1);
      ymin <= YW'(HEIGHT-1);
      xmax <= '0;
      ymax <= '0;
      found <= 1'b0;
      pend <= 1'b0;
      pend_data <= '0;
    end else begin
      pend <= hold_acc;
      pend_data <= on_box ? BOX_COLOR : hold_din;
      if (pop && motion) begin
        found <= 1'b1;
        xmin <= x < xmin ? x : xmin;
        xmax <= x > xmax ? x : xmax;
        ymin <= y < ymin ? y : ymin;
        ymax <= y > ymax ? y : ymax;
      end
      if (pop || hold_acc) begin
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) y <= y_last ? '0 : y + 1'b1;
      end
      if (pop && x_last && y_last) state <= DRAW;
      if (hold_acc && x_last && y_last) begin
        state <= SCAN;
        xmin <= XW'(WIDTH-1);
        ymin <= YW'(HEIGHT-1);
        xmax <= '0;
        ymax <= '0;
        found <= 1'b0;
      end
    end
endmodule

// File: tb/tb_draw_box_top.sv
// tb_draw_box_top: random-handshake frames checked against a box/outline reference model.
module tb_draw_box_top;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;
  logic clock = 0, reset = 0;
  logic in_wr_en = 0, base_wr_en = 0, hold_wr_en = 0, out_rd_en = 0;
  logic [23:0] in_din = 0, base_din = 0, hold_din = 0;
  logic in_full, base_full, hold_full, out_empty;
  logic [23:0] out_dout;
  logic [23:0] fin [N], fbase [N], fhold [N], fexp [N];
  logic [23:0] got [$];
  int nvec = 0, nerr = 0;

  draw_box_top #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(60), .BOX_COLOR(24'h0000FF), .FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .in_wr_en(in_wr_en), .in_din(in_din), .in_full(in_full),
    .base_wr_en(base_wr_en), .base_din(base_din), .base_full(base_full),
    .hold_wr_en(hold_wr_en), .hold_din(hold_din), .hold_full(hold_full),
    .out_rd_en(out_rd_en), .out_empty(out_empty), .out_dout(out_dout));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sum3(input logic [23:0] p);
    return int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
  endfunction

  // Reference: box over all motion pixels, then outline painted over the hold frame.
  task automatic build_exp();
    int x0 = W, y0 = H, x1 = -1, y1 = -1, d, px, py;
    bit f = 0, on;
    for (int p = 0; p < N; p++) begin
      d = sum3(fin[p]) - sum3(fbase[p]);
      if (d < 0) d = -d;
      if (d > 60) begin
        f = 1;
        px = p % W;
        py = p / W;
        if (px < x0) x0 = px;
        if (px > x1) x1 = px;
        if (py < y0) y0 = py;
        if (py > y1) y1 = py;
      end
    end
    for (int p = 0; p < N; p++) begin
      px = p % W;
      py = p / W;
      on = f && (((px == x0 || px == x1) && py >= y0 && py <= y1) ||
                 ((py == y0 || py == y1) && px >= x0 && px <= x1));
      fexp[p] = on ? 24'h0000FF : fhold[p];
    end
  endtask

  // mode 0: normal, 1: output stalled for a while, 2: reset partway through SCAN
  task automatic run_frame(input int mode, input string tag);
    int ii = 0, ib = 0, ih = 0, cyc = 0;
    bit stall;
    got = {};
    build_exp();
    while (got.size() < N && cyc < 5000) begin
      @(negedge clock);
      cyc++;
      if (mode == 2 && ii >= 12 && ib >= 12) begin
        in_wr_en = 0; base_wr_en = 0; hold_wr_en = 0; out_rd_en = 0;
        reset = 0;
        #1;
        check({tag, "_rst_out_empty"}, out_empty, 1);
        check({tag, "_rst_hold_full"}, hold_full, 1);
        check({tag, "_rst_in_full"}, in_full, 0);
        @(negedge clock);
        reset = 1;
        return;
      end
      stall = mode == 1 && cyc < 400;
      if (mode == 1 && cyc == 399) begin
        check({tag, "_bp_hold_full"}, hold_full, 1);
        check({tag, "_bp_accepted"}, ih, 16);
        check({tag, "_bp_out_empty"}, out_empty, 0);
      end
      in_wr_en = ii < N && !in_full && ($urandom % 4 != 0);
      if (in_wr_en) begin in_din = fin[ii]; ii++; end
      base_wr_en = ib < N && !base_full && ($urandom % 4 != 0);
      if (base_wr_en) begin base_din = fbase[ib]; ib++; end
      hold_wr_en = ih < N && ($urandom % 4 != 0);
      hold_din = ih < N ? fhold[ih] : 24'h0;
      if (hold_wr_en && !hold_full) ih++;
      out_rd_en = !stall && !out_empty && ($urandom % 3 != 0);
      if (out_rd_en) got.push_back(out_dout);
    end
    @(negedge clock);
    in_wr_en = 0; base_wr_en = 0; hold_wr_en = 0; out_rd_en = 0;
    check({tag, "_count"}, got.size(), N);
    for (int p = 0; p < N && p < got.size(); p++) check({tag, "_pix"}, got[p], fexp[p]);
    check({tag, "_drained"}, out_empty, 1);
  endtask

  task automatic quiet_frame();
    for (int p = 0; p < N; p++) begin
      fbase[p] = 24'h0;
      fin[p] = 24'h0;
      fhold[p] = $urandom & 24'hFFFFFF;
    end
  endtask

  initial begin
    #1;
    check("rst_in_full", in_full, 0);
    check("rst_base_full", base_full, 0);
    check("rst_out_empty", out_empty, 1);
    check("rst_out_dout", out_dout, 0);
    check("rst_hold_full", hold_full, 1);
    repeat (2) @(negedge clock);
    reset = 1;

    for (int p = 0; p < N; p++) begin
      fbase[p] = $urandom & 24'hFFFFFF;
      fin[p] = fbase[p];
      fhold[p] = 24'(p);
    end
    run_frame(0, "nomotion");

    quiet_frame();
    fin[10] = 24'hFFFFFF;
    run_frame(0, "single");
    if (got.size() > 10) check("single_idx10", got[10], 24'h0000FF);

    quiet_frame();
    fin[1 * W + 1] = 24'hFFFFFF;
    fin[2 * W + 5] = 24'h808080;
    run_frame(0, "twopix");

    quiet_frame();
    fin[5] = {8'd20, 8'd20, 8'd20};
    run_frame(0, "d60");
    if (got.size() > 5) check("d60_idx5", got[5], fhold[5]);

    quiet_frame();
    fin[5] = {8'd21, 8'd20, 8'd20};
    run_frame(0, "d61");
    if (got.size() > 5) check("d61_idx5", got[5], 24'h0000FF);

    for (int p = 0; p < N; p++) begin
      fbase[p] = $urandom & 24'hFFFFFF;
      fin[p] = ($urandom % 8 == 0) ? $urandom & 24'hFFFFFF : fbase[p];
      fhold[p] = $urandom & 24'hFFFFFF;
    end
    run_frame(1, "backpressure");

    run_frame(2, "abort");
    run_frame(0, "replay");

    for (int f = 0; f < 6; f++) begin
      for (int p = 0; p < N; p++) begin
        fbase[p] = $urandom & 24'hFFFFFF;
        fin[p] = (f == 5 || $urandom % 10 == 0) ? $urandom & 24'hFFFFFF : fbase[p];
        fhold[p] = $urandom & 24'hFFFFFF;
      end
      run_frame(0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
